// File: rtl/render_pkg.sv
// Shared scanline-renderer constants and the line-fetch FSM state encoding.
package render_pkg;

  localparam logic [11:0] TRANSPARENT = 12'hF0F;
  localparam int          MAP_COLS    = 40;
  localparam int          LINE_W      = 640;
  localparam int          SCREEN_H    = 480;

  typedef enum logic [2:0] {
    IDLE,
    BG_MAP,
    BG_WAIT,
    BG_PIX,
    SPR_PIX,
    FIN
  } state_t;

endpackage

// File: rtl/line_ram.sv
// One 640x12 scanline buffer: single write port, registered read port.
// Reads past the end of the line return zero.
module line_ram
  import render_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        we,
  input  logic [9:0]  wr_addr,
  input  logic [11:0] wr_data,
  input  logic [9:0]  rd_addr,
  output logic [11:0] rd_data
);

  logic [11:0] mem [LINE_W];

  // Pixel write; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (we && (wr_addr < 10'(LINE_W))) mem[wr_addr] <= wr_data;
  end

  // Registered read, zero for addresses beyond the visible line.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                            rd_data <= '0;
    else if (rd_addr < 10'(LINE_W))     rd_data <= mem[rd_addr];
    else                                rd_data <= '0;
  end

endmodule

// File: rtl/scanline_fetch.sv
// Builds one scanline into the back buffer: 40 background tiles fetched
// through the tilemap and tile ROMs, then an optional 16-pixel sprite
// overlay. Render reads the front buffer; swap exchanges the two.
module scanline_fetch #(
  parameter logic [11:0] TRANSPARENT = render_pkg::TRANSPARENT,
  parameter int          MAP_COLS    = render_pkg::MAP_COLS,
  parameter int          LINE_W      = render_pkg::LINE_W
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  input  logic [9:0]  spr_x,
  input  logic [8:0]  spr_y,
  output logic [10:0] map_addr,
  input  logic [5:0]  map_data,
  output logic [13:0] tile_addr,
  input  logic [11:0] tile_data,
  output logic [7:0]  spr_addr,
  input  logic [11:0] spr_data,
  input  logic [9:0]  rd_x,
  output logic [11:0] rd_data,
  input  logic        swap,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  import render_pkg::state_t;
  import render_pkg::IDLE;
  import render_pkg::BG_MAP;
  import render_pkg::BG_WAIT;
  import render_pkg::BG_PIX;
  import render_pkg::SPR_PIX;
  import render_pkg::FIN;

  state_t             state, nxt;
  logic               sel, rd_sel;
  logic [8:0]         ly, sy;
  logic [9:0]         sx;
  logic [5:0]         col, tile_idx;
  logic [3:0]         pix, spr_row;
  logic               spr_hit, last_col;
  logic [10:0]        spr_col_x;
  logic               wr_pend, wr_spr, wr_en;
  logic [9:0]         wr_addr;
  logic [11:0]        wr_data;
  logic [1:0][11:0]   ram_q;

  assign spr_hit   = (ly >= sy) && ({1'b0, ly} < ({1'b0, sy} + 10'd16));
  assign spr_row   = 4'(ly - sy);
  assign spr_col_x = {1'b0, sx} + {7'd0, pix};
  assign last_col  = (col == 6'(MAP_COLS - 1));

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and ROM addresses; addresses idle at zero outside their phase.
  always_comb begin
    nxt       = state;
    map_addr  = '0;
    tile_addr = '0;
    spr_addr  = '0;
    case (state)
      IDLE:    if (line_start)
                 nxt = (line_y >= 9'(render_pkg::SCREEN_H)) ? FIN : BG_MAP;
      BG_MAP:  begin
                 map_addr = 11'(int'(ly[8:4]) * MAP_COLS + int'(col));
                 nxt      = BG_WAIT;
               end
      BG_WAIT: nxt = BG_PIX;
      BG_PIX:  begin
                 tile_addr = {tile_idx, ly[3:0], pix};
                 if (pix == 4'd15) nxt = !last_col ? BG_MAP : (spr_hit ? SPR_PIX : FIN);
               end
      SPR_PIX: begin
                 spr_addr = {spr_row, pix};
                 if (pix == 4'd15) nxt = FIN;
               end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Line parameters, tile/pixel counters, busy and done.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ly <= '0; sx <= '0; sy <= '0;
      col <= '0; pix <= '0; tile_idx <= '0;
      busy <= 1'b0; done <= 1'b0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE:    if (line_start) begin
                   ly <= line_y; sx <= spr_x; sy <= spr_y;
                   col <= '0; pix <= '0; busy <= 1'b1;
                 end
        BG_WAIT: begin tile_idx <= map_data; pix <= '0; end
        BG_PIX:  begin
                   pix <= pix + 4'd1;
                   if (pix == 4'd15) col <= col + 6'd1;
                 end
        SPR_PIX: pix <= pix + 4'd1;
        FIN:     busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Remember each issued address so its ROM data is written next cycle;
  // sprite pixels falling off the right edge are never queued.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_pend <= 1'b0; wr_spr <= 1'b0; wr_addr <= '0;
    end else begin
      wr_pend <= 1'b0;
      wr_spr  <= 1'b0;
      if (state == BG_PIX) begin
        wr_pend <= 1'b1;
        wr_addr <= {col, pix};
      end else if (state == SPR_PIX) begin
        wr_pend <= (spr_col_x < 11'(LINE_W));
        wr_spr  <= 1'b1;
        wr_addr <= spr_col_x[9:0];
      end
    end
  end

  assign wr_en   = wr_pend && !(wr_spr && (spr_data == TRANSPARENT));
  assign wr_data = wr_spr ? spr_data : tile_data;

  // Buffer select; a swap mid-fill is refused and flagged until reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sel <= 1'b0; overrun <= 1'b0;
    end else if (swap) begin
      if (busy) overrun <= 1'b1;
      else      sel     <= ~sel;
    end
  end

  // Track which buffer was front when the read was launched.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) rd_sel <= 1'b0;
    else     rd_sel <= sel;
  end

  // Buffer[sel] is front, the other is back and takes the writes.
  for (genvar i = 0; i < 2; i++) begin : g_buf
    line_ram u_ram (
      .clk     (clk),
      .clr     (clr),
      .we      (wr_en && (sel != 1'(i))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_x),
      .rd_data (ram_q[i])
    );
  end

  assign rd_data = ram_q[rd_sel];

endmodule

// File: tb/tb_scanline_fetch.sv
// Directed + randomized bench for scanline_fetch with ROM models and a
// per-pixel line reference model.
module tb_scanline_fetch;

  logic        clk = 1'b0, clr = 1'b1, line_start = 1'b0, swap = 1'b0;
  logic [8:0]  line_y = '0, spr_y = '0;
  logic [9:0]  spr_x = '0, rd_x = '0;
  logic [10:0] map_addr;
  logic [5:0]  map_data;
  logic [13:0] tile_addr;
  logic [11:0] tile_data, spr_data, rd_data;
  logic [7:0]  spr_addr;
  logic        busy, done, overrun;

  logic [5:0]  map_mem  [2048];
  logic [11:0] tile_mem [16384];
  logic [11:0] spr_mem  [256];

  logic [11:0] ref_buf [2][640];
  bit          ref_valid [2];
  int          ref_sel, vecs, errs;
  bit          ref_ovr;

  always #5 clk = ~clk;

  scanline_fetch dut (
    .clk(clk), .clr(clr), .line_start(line_start), .line_y(line_y),
    .spr_x(spr_x), .spr_y(spr_y), .map_addr(map_addr), .map_data(map_data),
    .tile_addr(tile_addr), .tile_data(tile_data), .spr_addr(spr_addr),
    .spr_data(spr_data), .rd_x(rd_x), .rd_data(rd_data), .swap(swap),
    .busy(busy), .done(done), .overrun(overrun)
  );

  // ROMs with one cycle of latency.
  always @(posedge clk) begin
    map_data  <= map_mem[map_addr];
    tile_data <= tile_mem[tile_addr];
    spr_data  <= spr_mem[spr_addr];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] bg_px(input int ly, input int x);
    int idx;
    idx = int'(map_mem[(ly / 16) * 40 + x / 16]);
    return tile_mem[idx * 256 + (ly % 16) * 16 + (x % 16)];
  endfunction

  // Expected back-buffer contents after a completed fill.
  task automatic model_fill(input int ly, input int sx, input int sy);
    int b, r;
    b = 1 - ref_sel;
    if (ly >= 480) return;
    for (int x = 0; x < 640; x++) ref_buf[b][x] = bg_px(ly, x);
    if (ly >= sy && ly < sy + 16) begin
      r = ly - sy;
      for (int c = 0; c < 16; c++)
        if (sx + c < 640 && spr_mem[r * 16 + c] != 12'hF0F)
          ref_buf[b][sx + c] = spr_mem[r * 16 + c];
    end
    ref_valid[b] = 1'b1;
  endtask

  task automatic do_swap;
    swap = 1'b1; tick; swap = 1'b0;
    ref_sel = 1 - ref_sel;
  endtask

  task automatic read_front(input string tag);
    int b, nbad, fx;
    logic [11:0] fg, fw;
    b = ref_sel; nbad = 0; fx = 0; fg = '0; fw = '0;
    if (!ref_valid[b]) return;
    for (int x = 0; x < 640; x++) begin
      rd_x = 10'(x); tick;
      if (rd_data !== ref_buf[b][x]) begin
        if (nbad == 0) begin fx = x; fg = rd_data; fw = ref_buf[b][x]; end
        nbad++;
      end
    end
    vecs++;
    assert (nbad == 0) else begin
      errs++;
      $error("FAIL %s: %0d pixels differ, first x=%0d got %h expected %h", tag, nbad, fx, fg, fw);
    end
    rd_x = 10'($urandom_range(640, 1023)); tick;
    check({tag, "_oob"}, rd_data, 0);
  endtask

  task automatic spot(input string tag, input int x, input logic [11:0] want);
    rd_x = 10'(x); tick;
    check(tag, rd_data, want);
  endtask

  // Run one fill; optional swap / second line_start / reset injected at a cycle.
  task automatic fill(input string tag, input int ly, input int sx, input int sy,
                      input bit swap_start, input int swap_at, input int restart_at,
                      input int clr_at);
    int exp, done_at, cnt;
    bit hit;
    hit = (ly < 480) && (ly >= sy) && (ly < sy + 16);
    exp = (ly >= 480) ? 2 : (hit ? 738 : 722);
    line_y = 9'(ly); spr_x = 10'(sx); spr_y = 9'(sy);
    line_start = 1'b1; swap = swap_start;
    if (swap_start) ref_sel = 1 - ref_sel;
    tick;
    line_start = 1'b0; swap = 1'b0;
    check({tag, "_busy"}, busy, 1);
    done_at = 0;
    for (int n = 1; n <= 1000; n++) begin
      if (done) begin done_at = n; break; end
      if (n == clr_at) begin
        clr = 1'b1; #1;
        check({tag, "_clr_busy"}, busy, 0);
        check({tag, "_clr_done"}, done, 0);
        check({tag, "_clr_ovr"}, overrun, 0);
        tick;
        check({tag, "_clr_busy2"}, busy, 0);
        clr = 1'b0;
        ref_valid[1 - ref_sel] = 1'b0;
        ref_sel = 0; ref_ovr = 1'b0;
        cnt = 0;
        repeat (800) begin tick; if (done) cnt++; end
        check({tag, "_no_done"}, cnt, 0);
        check({tag, "_idle"}, busy, 0);
        return;
      end
      if (n == swap_at) begin swap = 1'b1; ref_ovr = 1'b1; end
      if (n == restart_at) begin line_start = 1'b1; line_y = 9'd480; end
      tick;
      swap = 1'b0; line_start = 1'b0;
    end
    check({tag, "_done_cycle"}, done_at, exp);
    check({tag, "_busy_clr"}, busy, 0);
    tick;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_ovr"}, overrun, ref_ovr);
    model_fill(ly, sx, sy);
  endtask

  initial begin
    int ly, sy, sx, cnt;
    vecs = 0; errs = 0; ref_sel = 0; ref_ovr = 1'b0;
    ref_valid[0] = 1'b0; ref_valid[1] = 1'b0;
    for (int a = 0; a < 16384; a++) tile_mem[a] = 12'(a);
    for (int a = 0; a < 2048; a++)  map_mem[a]  = 6'd3;
    for (int a = 0; a < 256; a++)   spr_mem[a]  = 12'hABC;

    // Reset state
    clr = 1'b1; repeat (3) tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovr", overrun, 0);
    check("rst_map_addr", map_addr, 0);
    check("rst_tile_addr", tile_addr, 0);
    check("rst_spr_addr", spr_addr, 0);
    check("rst_rd_data", rd_data, 0);
    clr = 1'b0; tick;

    // Plain background, sprite off-line
    fill("bg", 37, 0, 300, 0, 0, 0, 0);
    do_swap;
    read_front("bg_line");
    spot("bg_x20", 20, 12'h354);

    // Sprite with one transparent pixel
    spr_mem[7 * 16 + 4] = 12'hF0F;
    fill("spr", 37, 100, 30, 0, 0, 0, 0);
    do_swap;
    read_front("spr_line");
    spot("spr_x100", 100, 12'hABC);
    spot("spr_x104", 104, 12'h358);

    // Sprite clipped at the right edge
    for (int c = 0; c < 16; c++) spr_mem[7 * 16 + c] = 12'h123;
    fill("clip", 37, 630, 30, 0, 0, 0, 0);
    do_swap;
    read_front("clip_line");
    spot("clip_x5", 5, 12'h355);
    spot("clip_x635", 635, 12'h123);

    // Randomized content and placement
    for (int a = 0; a < 2048; a++)  map_mem[a]  = 6'($urandom);
    for (int a = 0; a < 16384; a++) tile_mem[a] = 12'($urandom);
    for (int a = 0; a < 256; a++)
      spr_mem[a] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
    for (int i = 0; i < 4; i++) begin
      ly = $urandom_range(0, 479);
      sy = (i == 3) ? $urandom_range(0, 511) : ly - $urandom_range(0, 15);
      if (sy < 0) sy = 0;
      sx = $urandom_range(0, 1023);
      fill("rnd", ly, sx, sy, i[0], 0, 0, 0);
      if (i[0]) read_front("rnd_old_front");
      do_swap;
      read_front("rnd_line");
    end

    // Swap and second line_start during a fill
    fill("ovr", 200, 50, 195, 0, 300, 400, 0);
    cnt = 0;
    repeat (800) begin tick; if (done) cnt++; end
    check("ovr_no_second_done", cnt, 0);
    check("ovr_sticky", overrun, 1);
    do_swap;
    read_front("ovr_line");

    // Off-screen line leaves the back buffer untouched
    fill("off", 480, 10, 470, 0, 0, 0, 0);
    do_swap;
    read_front("off_line");

    // Reset in the middle of a fill
    if (ref_sel == 0) do_swap;
    fill("abort", 100, 0, 0, 0, 0, 0, 500);
    do_swap;
    read_front("abort_sel");

    // Normal operation after reset
    fill("post", 123, 300, 120, 0, 0, 0, 0);
    do_swap;
    read_front("post_line");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/scanline_fetch.md
SCANLINE_FETCH -- requirements
Module: scanline_fetch

Interface
REQ-001 SHALL have ports: clk in 1, single clock; clr in 1, asynchronous active-high reset.
REQ-002 SHALL have port line_start in 1: one-cycle pulse from render requesting a fill of the back buffer.
REQ-003 SHALL have port line_y in 9: screen row to build, sampled with line_start.
REQ-004 SHALL have ports spr_x in 10, spr_y in 9: top-left of the 16x16 player sprite; both sampled with line_start.
REQ-005 SHALL have ports map_addr out 11 and map_data in 6: tilemap ROM port with 1-cycle latency.
REQ-006 SHALL have ports tile_addr out 14 and tile_data in 12: tile pixel ROM port with 1-cycle latency; tile_addr = {tile_idx, row[3:0], col[3:0]}.
REQ-007 SHALL have ports spr_addr out 8 and spr_data in 12: sprite ROM port with 1-cycle latency; spr_addr = {row[3:0], col[3:0]}.
REQ-008 SHALL have ports rd_x in 10 and rd_data out 12: render read port on the front buffer, 1-cycle latency.
REQ-009 SHALL have port swap in 1: pulse exchanging front and back buffers.
REQ-010 SHALL have outputs busy 1, done 1 (one-cycle pulse), overrun 1 (sticky).
REQ-011 SHALL have parameters TRANSPARENT = 12'hF0F, MAP_COLS = 40, LINE_W = 640.

Function
REQ-012 SHALL hold two 640x12 line buffers, front and back, selected by a 1-bit sel register.
REQ-013 SHALL use FSM states IDLE, BG_MAP, BG_WAIT, BG_PIX, SPR_PIX, FIN.
REQ-014 In IDLE, line_start SHALL latch line_y/spr_x/spr_y, set busy, and enter BG_MAP next cycle; line_start while busy SHALL be ignored.
REQ-015 If the latched line_y >= 480, the FSM SHALL go directly to FIN without writing the back buffer.
REQ-016 Per tile column c (0..39): BG_MAP 1 cycle, map_addr = (line_y>>4)*40 + c; BG_WAIT 1 cycle; BG_PIX 16 cycles issuing tile_addr for col 0..15, row = line_y[3:0].
REQ-017 Each tile_data SHALL be written to back[c*16+col] exactly one cycle after its address issue; the final write of one tile overlaps the next BG_MAP.
REQ-018 The background pass SHALL occupy cycles 1..720 after the sampling edge, with the last write on cycle 721.
REQ-019 SPR_PIX SHALL run (cycles 721..736) only when spr_y <= line_y < spr_y+16, issuing spr_addr for col 0..15 with row = line_y - spr_y; otherwise the FSM SHALL go to FIN at cycle 721.
REQ-020 A sprite pixel SHALL be written to back[spr_x+col] one cycle after issue, only if spr_data != TRANSPARENT and spr_x+col < 640 (11-bit sum, no wrap).
REQ-021 FIN SHALL last 1 cycle, assert done, clear busy, and return to IDLE; done SHALL appear on cycle 722 (no sprite), cycle 738 (sprite), or cycle 2 (line_y >= 480).
REQ-022 rd_data SHALL equal front[rd_x] registered one cycle later; rd_x >= 640 SHALL return 12'h000.
REQ-023 swap while not busy SHALL toggle sel; swap while busy SHALL be ignored and SHALL set overrun.
REQ-024 swap and line_start in the same IDLE cycle SHALL apply the swap first, so the fill targets the new back buffer.

Reset
REQ-025 clr SHALL force state IDLE, sel=0, busy=0, done=0, overrun=0, all ROM addresses 0, and rd_data=0; buffer contents are not reset.
REQ-026 clr during a fill SHALL abort it immediately; the partial back-buffer contents are undefined.

Structure
REQ-027 State encoding, TRANSPARENT, LINE_W, MAP_COLS, and screen height 480 SHALL live in the shared package render_pkg.
REQ-028 The two buffers SHALL be instances of one sub-module line_ram (640x12, 1 write port, 1 registered read port).

Verification
REQ-029 Map all tile 3 with tile pixel = {tile_idx,row,col} low 12 bits, line_start with line_y=37 -> done at cycle 722, after swap back[x] = {3,5,x%16}.
REQ-030 spr_x=100, spr_y=30, line_y=37, sprite pixel col 4 = F0F and others 12'hABC -> done at 738, x=100..115 = ABC except x=104 = background.
REQ-031 spr_x=630 on the sprite row -> only x=630..639 are overwritten, with no write at x<16.
REQ-032 swap pulse at cycle 300 of a fill -> sel unchanged, overrun=1 and held until clr; the second line_start at cycle 400 is ignored.
REQ-033 line_y=480 -> done at cycle 2, back buffer bit-identical to before.
REQ-034 clr asserted at cycle 500 -> busy=0, done=0, sel=0 on the next edge, with no done pulse ever issued.
